// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the parametrised register file.
//   state_e    - clear sequencer state (IDLE, CLEAR)
//   DEF_WIDTH  - default data bits per entry
//   DEF_DEPTH  - default number of entries (power of two, >= 2)
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port of the register file.
// Output data is registered, so the port has one cycle of latency. The
// same-cycle write and clear are forwarded so the read sees the post-edge
// contents (write-first).
// Optional feature: REGFILE_ZERO_REG_EN forces index 0 to read as zero.
// Ports:
//   clk_i       rising-edge clock
//   reset_n_i   synchronous active-low reset, clears rd_o
//   idx_i       read address
//   entry_i     current stored contents of entry idx_i
//   wr_en_i     write accepted this cycle
//   wr_idx_i    write address
//   wr_data_i   write data
//   clr_en_i    clear sequencer zeroes clr_idx_i this cycle
//   clr_idx_i   entry being cleared
//   rd_o        registered read data
module regfile_rdport #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [AW-1:0]    idx_i,
  input  logic [WIDTH-1:0] entry_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_idx_i,
  output logic [WIDTH-1:0] rd_o
);

  logic [WIDTH-1:0] rd_d, rd_q;

  // Writes and clears are mutually exclusive, so priority between them is moot.
  always_comb begin
    rd_d = entry_i;
    if (wr_en_i && (wr_idx_i == idx_i)) rd_d = wr_data_i;
    if (clr_en_i && (clr_idx_i == idx_i)) rd_d = '0;
`ifdef REGFILE_ZERO_REG_EN
    if (idx_i == '0) rd_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) rd_q <= '0;
    else            rd_q <= rd_d;
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read / 1-write register file with a hardware
// clear sequencer and a dropped-write pulse.
// Optional feature: REGFILE_ZERO_REG_EN makes entry 0 a hard-wired zero;
// writes to it are discarded and pulse wr_drop.
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   a_index    read port A address     b_index   read port B address
//   c_index    write address           we        write enable
//   d_input    write data              clr_req   request to zero all entries
//   a_output   registered port A data  b_output  registered port B data
//   clr_busy   clear sequencer active  clr_done  pulse after final entry cleared
//   wr_drop    pulse one cycle after a discarded write
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    a_index,
  input  logic [AW-1:0]    b_index,
  input  logic [AW-1:0]    c_index,
  input  logic             we,
  input  logic [WIDTH-1:0] d_input,
  input  logic             clr_req,
  output logic [WIDTH-1:0] a_output,
  output logic [WIDTH-1:0] b_output,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  state_e           state_q;
  logic [AW-1:0]    ptr_q;
  logic             clr_done_q;
  logic             wr_drop_q;

  logic busy;
  logic zero_blk;
  logic wr_acc;
  logic wr_drop_d;

  assign busy = (state_q == CLEAR);

`ifdef REGFILE_ZERO_REG_EN
  assign zero_blk = (c_index == '0);
`else
  assign zero_blk = 1'b0;
`endif

  assign wr_acc    = we && !busy && !zero_blk;
  assign wr_drop_d = we && (busy || zero_blk);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      wr_drop_q  <= wr_drop_d;
      clr_done_q <= 1'b0;
      if (wr_acc) mem_q[c_index] <= d_input;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          mem_q[ptr_q] <= '0;
          // Terminal count: the walk covers exactly DEPTH cycles.
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            clr_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_busy = busy;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

  regfile_rdport #(.WIDTH(WIDTH), .AW(AW)) u_rd_a (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .idx_i     (a_index),
    .entry_i   (mem_q[a_index]),
    .wr_en_i   (wr_acc),
    .wr_idx_i  (c_index),
    .wr_data_i (d_input),
    .clr_en_i  (busy),
    .clr_idx_i (ptr_q),
    .rd_o      (a_output)
  );

  regfile_rdport #(.WIDTH(WIDTH), .AW(AW)) u_rd_b (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .idx_i     (b_index),
    .entry_i   (mem_q[b_index]),
    .wr_en_i   (wr_acc),
    .wr_idx_i  (c_index),
    .wr_data_i (d_input),
    .clr_en_i  (busy),
    .clr_idx_i (ptr_q),
    .rd_o      (b_output)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param (default 16 x 8). Stimulus is applied on the
// falling edge; a reference model predicts the post-edge outputs and pushes
// them into a queue that a separate monitor drains after each rising edge.
// Honors REGFILE_ZERO_REG_EN when defined for the build.
module tb_regfile_param;

  localparam int W = 16;
  localparam int D = 8;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   a_index = '0, b_index = '0, c_index = '0;
  logic         we = 1'b0;
  logic [W-1:0] d_input = '0;
  logic         clr_req = 1'b0;
  logic [W-1:0] a_output, b_output;
  logic         clr_busy, clr_done, wr_drop;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_index  (a_index),
    .b_index  (b_index),
    .c_index  (c_index),
    .we       (we),
    .d_input  (d_input),
    .clr_req  (clr_req),
    .a_output (a_output),
    .b_output (b_output),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain array plus a count of clear cycles still to run.
  logic [W-1:0] m_mem [D];
  int           m_rem = 0;

  task automatic cyc(input logic rst_n, input int a, input int b, input int c,
                     input logic w, input logic [W-1:0] d, input logic clr);
    exp_t e;
    bit   drop;
    bit   done;
    @(negedge clk);
    reset_n = rst_n; a_index = 3'(a); b_index = 3'(b); c_index = 3'(c);
    we = w; d_input = d; clr_req = clr;
    drop = 0; done = 0;
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_rem = 0;
    end else begin
      drop = w && ((m_rem > 0) || (ZR && c == 0));
      if (w && !drop) m_mem[c] = d;
      if (m_rem > 0) begin
        m_mem[D - m_rem] = '0;
        m_rem--;
        done = (m_rem == 0);
      end else if (clr) begin
        m_rem = D;
      end
    end
    e.a = m_mem[a];
    e.b = m_mem[b];
    e.busy = (m_rem > 0);
    e.done = done;
    e.drop = drop;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int a, input int b);
    cyc(1'b1, a, b, 0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: outputs settle after each rising edge; compare to the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 5;
      if (a_output !== e.a) begin
        n_fail++; $display("FAIL a_output: got %h expected %h at %0t", a_output, e.a, $time);
      end
      if (b_output !== e.b) begin
        n_fail++; $display("FAIL b_output: got %h expected %h at %0t", b_output, e.b, $time);
      end
      if (clr_busy !== e.busy) begin
        n_fail++; $display("FAIL clr_busy: got %b expected %b at %0t", clr_busy, e.busy, $time);
      end
      if (clr_done !== e.done) begin
        n_fail++; $display("FAIL clr_done: got %b expected %b at %0t", clr_done, e.done, $time);
      end
      if (wr_drop !== e.drop) begin
        n_fail++; $display("FAIL wr_drop: got %b expected %b at %0t", wr_drop, e.drop, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = '0;

    // Reset, then read every entry on both ports.
    cyc(1'b0, 0, 0, 0, 1'b0, '0, 1'b0);
    cyc(1'b0, 0, 0, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < D; i++) idle(i, D - 1 - i);

    // Write then read back on both ports.
    cyc(1'b1, 0, 0, 3, 1'b1, 16'hBEEF, 1'b0);
    idle(3, 3);
    idle(3, 3);

    // Same-cycle write bypass, then plain read on port B.
    cyc(1'b1, 5, 0, 5, 1'b1, 16'h1234, 1'b0);
    idle(0, 5);

    // Fill, then clear with a write dropped mid-walk.
    for (int i = 0; i < D; i++) cyc(1'b1, i, i, i, 1'b1, W'(16'h1111 * i), 1'b0);
    cyc(1'b1, 1, 2, 0, 1'b0, '0, 1'b1);
    for (int k = 0; k < D + 2; k++) begin
      if (k == 3) cyc(1'b1, 2, 6, 2, 1'b1, 16'hAAAA, 1'b0);
      else if (k == 4) cyc(1'b1, 2, 2, 0, 1'b0, '0, 1'b1); // ignored while busy
      else idle(k % D, (k + 4) % D);
    end
    for (int i = 0; i < D; i++) idle(i, i);

    // Refill, start a clear and reset in its fourth cycle.
    for (int i = 0; i < D; i++) cyc(1'b1, 0, 0, i, 1'b1, W'(16'h2222 + i), 1'b0);
    cyc(1'b1, 0, 0, 0, 1'b0, '0, 1'b1);
    idle(7, 6);
    idle(7, 6);
    idle(7, 6);
    cyc(1'b0, 7, 6, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < D + 2; i++) idle(i % D, (i + 1) % D);

    // Entry 0 behaviour (hard zero only when the feature is enabled).
    cyc(1'b1, 0, 0, 0, 1'b1, 16'hFFFF, 1'b0);
    idle(0, 0);
    idle(0, 1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 99) != 0), $urandom_range(0, D - 1), $urandom_range(0, D - 1),
          $urandom_range(0, D - 1), $urandom_range(0, 1), W'($urandom),
          ($urandom_range(0, 24) == 0));
    end

    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
